// File: rtl/sevenseg_bank.sv
// sevenseg_bank: multi-digit hexadecimal seven-segment display controller.
//
// Holds a loaded value and decodes every nibble to active-low segments
// {g,f,e,d,c,b,a}. Digits can be blanked by the global enable, by
// per-digit enables, by per-digit blinking and by leading-zero
// suppression. A time-multiplexed scan output serves common-anode
// displays.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load       - capture value into value_q on this edge
//   value      - DIGITS hex nibbles, digit 0 least significant
//   enable     - global display enable (0 blanks all digits)
//   digit_en   - per-digit enable (0 blanks that digit)
//   blink_mask - per-digit blink select
//   lz_blank   - suppress leading zeros (digit 0 is never suppressed)
//   segs       - registered active-low segments, 7 bits per digit
//   scan_seg   - segments of the currently scanned digit
//   scan_an    - active-low one-hot anode select
module sevenseg_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  enable,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  output logic [7*DIGITS-1:0]   segs,
  output logic [6:0]            scan_seg,
  output logic [DIGITS-1:0]     scan_an
);

  localparam int BW = $clog2(BLINK_DIV < 2 ? 2 : BLINK_DIV);
  localparam int SW = $clog2(SCAN_DIV < 2 ? 2 : SCAN_DIV);
  localparam int IW = $clog2(DIGITS < 2 ? 2 : DIGITS);
  localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0011000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  logic [4*DIGITS-1:0] value_q;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       scan_idx;
  logic [IW-1:0]       scan_idx_next;
  logic                scan_wrap;
  logic [DIGITS-1:0]   zero_above;
  logic [7*DIGITS-1:0] segs_next;
  logic [DIGITS-1:0]   an_next;

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  // Any index at or beyond the last digit (including unreachable codes)
  // advances to 0, so a corrupted index self-heals on the next slot.
  always_comb begin
    scan_idx_next = scan_idx;
    if (scan_wrap) begin
      if (scan_idx >= IW'(DIGITS - 1)) scan_idx_next = '0;
      else                             scan_idx_next = scan_idx + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic nib_zero;
      logic lz_term;
      logic blank;

      assign nib_zero = (value_q[4*gi +: 4] == 4'h0);

      // zero_above[i]: nibbles DIGITS-1 down to i are all zero.
      if (gi == DIGITS - 1) begin : g_top
        assign zero_above[gi] = nib_zero;
      end else begin : g_chain
        assign zero_above[gi] = nib_zero & zero_above[gi+1];
      end

      if (gi == 0) begin : g_lz0
        assign lz_term = 1'b0;
      end else begin : g_lzn
        assign lz_term = lz_blank & zero_above[gi];
      end

      assign blank = ~enable | ~digit_en[gi] | (blink_mask[gi] & ~blink_phase) | lz_term;
      assign segs_next[7*gi +: 7] = blank ? 7'h7F : hex_decode(value_q[4*gi +: 4]);
      assign an_next[gi] = (scan_idx_next != IW'(gi));
    end
  endgenerate

  // Scanned segments come straight from registers through a mux.
  always_comb begin
    scan_seg = segs[6:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) scan_seg = segs[7*i +: 7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      segs        <= '1;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      scan_an     <= AN_RST;
    end else begin
      if (load) value_q <= value;
      segs <= segs_next;

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (scan_wrap) scan_cnt <= '0;
      else           scan_cnt <= scan_cnt + 1'b1;

      scan_idx <= scan_idx_next;
      scan_an  <= an_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_bank.sv
// Directed testbench for sevenseg_bank with DIGITS=4, BLINK_DIV=4,
// SCAN_DIV=2. Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a period after the active edge.
module tb_sevenseg_bank;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] DA = 7'b0001000;
  localparam logic [6:0] DF = 7'b0001110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        enable = 1'b0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic [27:0] segs;
  logic [6:0]  scan_seg;
  logic [3:0]  scan_an;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;   // clock edges since the last reset release

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  sevenseg_bank #(.DIGITS(4), .BLINK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .enable(enable),
    .digit_en(digit_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .segs(segs), .scan_seg(scan_seg), .scan_an(scan_an)
  );

  function automatic logic [6:0] tb_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] full_dec(input logic [15:0] v);
    return {tb_dec(v[15:12]), tb_dec(v[11:8]), tb_dec(v[7:4]), tb_dec(v[3:0])};
  endfunction

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    if (segs !== 28'hFFFFFFF) begin n_bad++; $display("FAIL reset_segs got %h want fffffff", segs); end
    n_cmp++;
    if (scan_an !== 4'b1110) begin n_bad++; $display("FAIL reset_scan_an got %b want 1110", scan_an); end
    n_cmp++;
    if (scan_seg !== BL) begin n_bad++; $display("FAIL reset_scan_seg got %b want %b", scan_seg, BL); end
    n_cmp++;
    @(posedge clk); #1;
    if (segs !== 28'hFFFFFFF) begin n_bad++; $display("FAIL reset_held_segs got %h want fffffff", segs); end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_decode;
    value = 16'h12AF; load = 1'b1; enable = 1'b1; digit_en = 4'hF;
    blink_mask = 4'h0; lz_blank = 1'b0;
    @(negedge clk);
    load = 1'b0;
    if (segs !== {4{D0}}) begin n_bad++; $display("FAIL decode_latency got %h want %h", segs, {4{D0}}); end
    n_cmp++;
    @(negedge clk);
    if (segs !== {D1, D2, DA, DF}) begin n_bad++; $display("FAIL decode_12af got %h want %h", segs, {D1, D2, DA, DF}); end
    n_cmp++;
    $display("decode 12AF -> %h", segs);
  endtask

  task automatic test_lz;
    lz_blank = 1'b1; value = 16'h0050; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    if (segs !== {BL, BL, D5, D0}) begin n_bad++; $display("FAIL lz_0050 got %h want %h", segs, {BL, BL, D5, D0}); end
    n_cmp++;
    value = 16'h0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    if (segs !== {BL, BL, BL, D0}) begin n_bad++; $display("FAIL lz_0000 got %h want %h", segs, {BL, BL, BL, D0}); end
    n_cmp++;
    $display("lz 0000 -> %h", segs);
  endtask

  task automatic test_back_to_back;
    logic [15:0] v [3];
    v[0] = 16'h3456; v[1] = 16'h789B; v[2] = 16'hCDE0;
    lz_blank = 1'b0; load = 1'b1; value = v[0];
    @(negedge clk); value = v[1];
    @(negedge clk);
    if (segs !== full_dec(v[0])) begin n_bad++; $display("FAIL b2b_0 got %h want %h", segs, full_dec(v[0])); end
    n_cmp++;
    value = v[2];
    @(negedge clk);
    if (segs !== full_dec(v[1])) begin n_bad++; $display("FAIL b2b_1 got %h want %h", segs, full_dec(v[1])); end
    n_cmp++;
    load = 1'b0;
    @(negedge clk);
    if (segs !== full_dec(v[2])) begin n_bad++; $display("FAIL b2b_2 got %h want %h", segs, full_dec(v[2])); end
    n_cmp++;
    $display("back-to-back loads done");
  endtask

  task automatic test_blink;
    logic [6:0] exp0;
    value = 16'h12AF; load = 1'b1; blink_mask = 4'b0001;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      // blink_phase after m edges is visible when (m/4) is even; segs
      // show the phase held before the latest edge.
      exp0 = ((((cyc - 1) / 4) % 2) == 0) ? DF : BL;
      if (segs[6:0] !== exp0) begin n_bad++; $display("FAIL blink_d0 cyc %0d got %b want %b", cyc, segs[6:0], exp0); end
      n_cmp++;
      if (segs[27:7] !== {D1, D2, DA}) begin n_bad++; $display("FAIL blink_steady cyc %0d got %h want %h", cyc, segs[27:7], {D1, D2, DA}); end
      n_cmp++;
      @(negedge clk);
    end
    digit_en = 4'b1011;
    @(negedge clk);
    if (segs[20:14] !== BL || segs[27:21] !== D1) begin
      n_bad++; $display("FAIL digit_en_d2 got %h want d3=%b d2=%b", segs, D1, BL);
    end
    n_cmp++;
    enable = 1'b0;
    @(negedge clk);
    if (segs !== 28'hFFFFFFF) begin n_bad++; $display("FAIL enable_off got %h want fffffff", segs); end
    n_cmp++;
    $display("blink/enable done");
  endtask

  task automatic test_scan;
    logic [6:0] exp_slice [4];
    int idx;
    exp_slice[0] = DF; exp_slice[1] = DA; exp_slice[2] = D2; exp_slice[3] = D1;
    enable = 1'b1; digit_en = 4'hF; blink_mask = 4'h0;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      idx = (cyc / 2) % 4;
      if (scan_an !== ~(4'b0001 << idx)) begin n_bad++; $display("FAIL scan_an cyc %0d got %b want %b", cyc, scan_an, ~(4'b0001 << idx)); end
      n_cmp++;
      if (scan_seg !== exp_slice[idx]) begin n_bad++; $display("FAIL scan_seg cyc %0d got %b want %b", cyc, scan_seg, exp_slice[idx]); end
      n_cmp++;
      @(negedge clk);
    end
    $display("scan rotation done");
  endtask

  task automatic test_mid_reset;
    int k;
    lz_blank = 1'b1;
    k = 0;
    while ((cyc % 4) != 3 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if ((cyc % 4) != 3) begin n_bad++; $display("FAIL midrst_align got cyc %0d want cyc%%4==3", cyc); end
    n_cmp++;
    value = 16'hFFFF; load = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    if (segs !== 28'hFFFFFFF) begin n_bad++; $display("FAIL midrst_segs got %h want fffffff", segs); end
    n_cmp++;
    if (scan_an !== 4'b1110) begin n_bad++; $display("FAIL midrst_scan_an got %b want 1110", scan_an); end
    n_cmp++;
    if (scan_seg !== BL) begin n_bad++; $display("FAIL midrst_scan_seg got %b want %b", scan_seg, BL); end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0;
    @(negedge clk);
    if (segs !== {BL, BL, BL, D0}) begin n_bad++; $display("FAIL midrst_after got %h want %h", segs, {BL, BL, BL, D0}); end
    n_cmp++;
    if (scan_an !== 4'b1110) begin n_bad++; $display("FAIL midrst_after_an got %b want 1110", scan_an); end
    n_cmp++;
    $display("mid-operation reset done");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_lz();
    test_back_to_back();
    test_blink();
    test_scan();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_bank.md
Name: sevenseg_bank

Overview:
- Parametrised multi-digit hexadecimal seven-segment display controller for board-level debug output from the processor.
- Holds a loaded value in an internal register and decodes every digit to active-low segments.
- Adds per-digit enable, leading-zero blanking, per-digit blink and a time-multiplexed scan output.
- Drives both direct per-digit HEX pins and multiplexed common-anode displays.

Parameters:
- DIGITS, 6: number of hex digits; legal range 1..8. Digit 0 is least significant.
- BLINK_DIV, 25000000: blink half-period in clock cycles; must be >= 1.
- SCAN_DIV, 50000: clock cycles per scan slot; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  when 1 at a clock edge, value is captured into value_q.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i].
- enable  in  1  global display enable; 0 blanks all digits.
- digit_en  in  DIGITS  per-digit enable; 0 blanks that digit.
- blink_mask  in  DIGITS  1 = digit blinks.
- lz_blank  in  1  1 = suppress leading zeros.
- segs  out  7*DIGITS  registered active-low segments; slice i = segs[7i+6:7i], bit order {g,f,e,d,c,b,a}.
- scan_seg  out  7  active-low segments of the currently scanned digit.
- scan_an  out  DIGITS  active-low one-hot anode select.

Behaviour:
- Reset values (async assert, rst_n low):
  - value_q = 0
  - segs = all ones (every digit blank)
  - blink counter = 0; blink_phase = 1 (visible)
  - scan counter = 0; scan index = 0
  - scan_an = ~1 (digit 0 selected); scan_seg = 7'b1111111
- Reset release: state updates begin on the first clk edge after rst_n is sampled high.
- Load:
  - value_q <= value on any edge with load = 1; otherwise value_q holds.
  - load has no handshake and may be asserted every cycle.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blank = 1111111.
- Blank condition for digit i (any term true):
  - enable = 0
  - digit_en[i] = 0
  - blink_mask[i] = 1 and blink_phase = 0
  - lz_blank = 1, i > 0, and nibbles DIGITS-1 down to i of value_q are all zero
  - Digit 0 is never leading-zero blanked.
- Latency:
  - segs register from value_q and the current controls every cycle.
  - load at edge k -> value_q at edge k -> segs reflect it at edge k+1.
  - Control inputs (enable, digit_en, blink_mask, lz_blank) reach segs one edge after being sampled.
- Blink:
  - Counter runs 0..BLINK_DIV-1 continuously.
  - On the wrap edge: counter -> 0 and blink_phase toggles.
  - Blink state is not disturbed by load or by blink_mask changes.
  - BLINK_DIV = 1 toggles blink_phase every cycle.
- Scan:
  - Counter runs 0..SCAN_DIV-1; on the wrap edge the scan index advances by 1, wrapping DIGITS-1 -> 0.
  - scan_an = ~(1 << index), registered with the index.
  - scan_seg = segs slice[index]; combinational from registered signals, glitch-free at edges.
  - DIGITS = 1: scan_an stays 0 and the index never changes.
  - SCAN_DIV = 1: advance every cycle.
- Simultaneous events: load, blink wrap and scan wrap on the same edge all take effect independently; none is dropped.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values; no partial load survives.
- Widths:
  - Counters are sized $clog2(max(DIV,2)).
  - The index is sized $clog2(max(DIGITS,2)).
  - Unused index codes are unreachable; if forced, the index is treated as 0 on the next advance.

Test Plan:
Bench parameters: DIGITS=4, BLINK_DIV=4, SCAN_DIV=2.
1. Reset:
   - Stimulus: hold rst_n=0 mid-clock.
   - Response: segs=28'hFFFFFFF, scan_an=4'b1110, scan_seg=7'b1111111 immediately, without a clock edge.
2. Decode:
   - Stimulus: load=1, value=16'h12AF, enable=1, digit_en=4'hF, blink_mask=0, lz_blank=0.
   - Response: two edges later digit3=1111001, digit2=0100100, digit1=0001000, digit0=0001110.
3. Leading-zero blanking:
   - Stimulus: lz_blank=1, load 16'h0050.
   - Response: digits 3 and 2 = 1111111, digit1=0010010, digit0=1000000.
   - Then load 16'h0000.
   - Response: only digit0=1000000 is lit.
4. Blink and enables:
   - Stimulus: blink_mask=4'b0001.
   - Response: digit0 alternates 4 cycles visible / 4 cycles blank; digits 1-3 are steady.
   - Then digit_en=4'b1011.
   - Response: digit2 = 1111111 one edge later.
   - Then enable=0.
   - Response: all digits blank one edge later.
5. Scan rotation:
   - Stimulus: free-run the scan.
   - Response: scan_an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every 2 cycles; scan_seg equals segs slice[index] on every cycle.
6. Reset mid-operation:
   - Stimulus: pulse rst_n low while load=1 and a blink wrap coincide.
   - Response: all outputs blank; after release, segs show 1000000 on digit0 within 1 edge (value_q=0, lz_blank=1).
